// File: rtl/writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : writeback_ctrl
// Brief    : Dual-lane result writeback buffer. A 4-entry FIFO of paired
//            lane results feeding two register-file write ports, with
//            zero-register filtering, same-register collision resolution,
//            flush, and a pending-write scoreboard mask.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        res_valid_1,
  input  logic [4:0]  res_reg_1,
  input  logic [31:0] res_data_1,
  input  logic        res_valid_2,
  input  logic [4:0]  res_reg_2,
  input  logic [31:0] res_data_2,
  output logic        res_ready,
  output logic        write_reg_flag_1,
  output logic [4:0]  write_reg_1,
  output logic [31:0] write_data_1,
  output logic        write_reg_flag_2,
  output logic [4:0]  write_reg_2,
  output logic [31:0] write_data_2,
  output logic [31:0] pend_mask,
  output logic [2:0]  count
);

  localparam int         DEPTH      = 4;
  localparam logic [2:0] FULL_COUNT = 3'd4;

  // Entry storage, one slot per lane. Occupancy is tracked by the pointers
  // and count, so the storage itself needs no reset.
  logic        s1_vld_q  [DEPTH];
  logic [4:0]  s1_reg_q  [DEPTH];
  logic [31:0] s1_data_q [DEPTH];
  logic        s2_vld_q  [DEPTH];
  logic [4:0]  s2_reg_q  [DEPTH];
  logic [31:0] s2_data_q [DEPTH];

  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q,  count_d;

  logic        wflag1_q, wflag1_d;
  logic [4:0]  wreg1_q,  wreg1_d;
  logic [31:0] wdata1_q, wdata1_d;
  logic        wflag2_q, wflag2_d;
  logic [4:0]  wreg2_q,  wreg2_d;
  logic [31:0] wdata2_q, wdata2_d;

  logic        lane1_ok;
  logic        lane2_ok;
  logic        enq;
  logic        deq;

  logic [DEPTH-1:0]      occupied;
  logic [DEPTH:0][31:0]  pend_chain;
  logic [31:0]           port_pend;

  // Slot admission: writes to register 0 are dropped, and when both lanes
  // target the same register only the younger lane (lane 2) is kept.
  always_comb begin
    lane2_ok = res_valid_2 && (res_reg_2 != 5'd0);
    lane1_ok = res_valid_1 && (res_reg_1 != 5'd0) &&
               !(lane2_ok && (res_reg_1 == res_reg_2));
  end

  // Ready is held low during reset so nothing is offered while the block is
  // being cleared; an entry is only allocated if at least one slot survives.
  assign res_ready = rst_n && (count_q < FULL_COUNT) && !flush;
  assign enq       = res_ready && (lane1_ok || lane2_ok);
  assign deq       = (count_q != 3'd0) && !flush;

  // Next-state: flush empties the FIFO, otherwise advance pointers/count and
  // load the head entry into the write ports on a dequeue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wflag1_d = 1'b1;
    wreg1_d  = wreg1_q;
    wdata1_d = wdata1_q;
    wflag2_d = 1'b1;
    wreg2_d  = wreg2_q;
    wdata2_d = wdata2_q;
    if (flush) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + 2'd1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
        wflag1_d = ~s1_vld_q[rd_ptr_q];
        wreg1_d  = s1_reg_q[rd_ptr_q];
        wdata1_d = s1_data_q[rd_ptr_q];
        wflag2_d = ~s2_vld_q[rd_ptr_q];
        wreg2_d  = s2_reg_q[rd_ptr_q];
        wdata2_d = s2_data_q[rd_ptr_q];
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and write-port registers; reset clears everything and idles both
  // write enables so no buffered result is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      wflag1_q <= 1'b1;
      wreg1_q  <= 5'd0;
      wdata1_q <= 32'd0;
      wflag2_q <= 1'b1;
      wreg2_q  <= 5'd0;
      wdata2_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wflag1_q <= wflag1_d;
      wreg1_q  <= wreg1_d;
      wdata1_q <= wdata1_d;
      wflag2_q <= wflag2_d;
      wreg2_q  <= wreg2_d;
      wdata2_q <= wdata2_d;
    end
  end

  // Entry write at the tail; a dropped slot is stored with its valid low.
  always_ff @(posedge clk) begin
    if (enq) begin
      s1_vld_q[wr_ptr_q]  <= lane1_ok;
      s1_reg_q[wr_ptr_q]  <= res_reg_1;
      s1_data_q[wr_ptr_q] <= res_data_1;
      s2_vld_q[wr_ptr_q]  <= lane2_ok;
      s2_reg_q[wr_ptr_q]  <= res_reg_2;
      s2_data_q[wr_ptr_q] <= res_data_2;
    end
  end

  // Per-entry pending contribution, OR-chained across the buffer. An entry
  // is live when its distance from the read pointer is below count.
  assign pend_chain[0] = '0;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [1:0]  slot_offset;
    logic [31:0] entry_pend;

    assign slot_offset  = 2'(gi) - rd_ptr_q;
    assign occupied[gi] = ({1'b0, slot_offset} < count_q);

    // Mark the destination registers of this entry's valid slots.
    always_comb begin
      entry_pend = '0;
      if (occupied[gi] && s1_vld_q[gi]) begin
        entry_pend[s1_reg_q[gi]] = 1'b1;
      end
      if (occupied[gi] && s2_vld_q[gi]) begin
        entry_pend[s2_reg_q[gi]] = 1'b1;
      end
    end

    assign pend_chain[gi+1] = pend_chain[gi] | entry_pend;
  end

  // Results sitting on an active write port are still pending until the
  // register file commits them.
  always_comb begin
    port_pend = '0;
    if (!wflag1_q) begin
      port_pend[wreg1_q] = 1'b1;
    end
    if (!wflag2_q) begin
      port_pend[wreg2_q] = 1'b1;
    end
  end

  assign pend_mask        = (pend_chain[DEPTH] | port_pend) & ~32'h1;
  assign count            = count_q;
  assign write_reg_flag_1 = wflag1_q;
  assign write_reg_1      = wreg1_q;
  assign write_data_1     = wdata1_q;
  assign write_reg_flag_2 = wflag2_q;
  assign write_reg_2      = wreg2_q;
  assign write_data_2     = wdata2_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_ctrl
// Brief    : Self-checking bench for writeback_ctrl: directed vector table,
//            hand-written corner sequences and random traffic compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        res_valid_1 = 1'b0;
  logic [4:0]  res_reg_1 = 5'd0;
  logic [31:0] res_data_1 = 32'd0;
  logic        res_valid_2 = 1'b0;
  logic [4:0]  res_reg_2 = 5'd0;
  logic [31:0] res_data_2 = 32'd0;
  logic        res_ready;
  logic        write_reg_flag_1;
  logic [4:0]  write_reg_1;
  logic [31:0] write_data_1;
  logic        write_reg_flag_2;
  logic [4:0]  write_reg_2;
  logic [31:0] write_data_2;
  logic [31:0] pend_mask;
  logic [2:0]  count;

  always #5 clk = ~clk;

  writeback_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .res_valid_1      (res_valid_1),
    .res_reg_1        (res_reg_1),
    .res_data_1       (res_data_1),
    .res_valid_2      (res_valid_2),
    .res_reg_2        (res_reg_2),
    .res_data_2       (res_data_2),
    .res_ready        (res_ready),
    .write_reg_flag_1 (write_reg_flag_1),
    .write_reg_1      (write_reg_1),
    .write_data_1     (write_data_1),
    .write_reg_flag_2 (write_reg_flag_2),
    .write_reg_2      (write_reg_2),
    .write_data_2     (write_data_2),
    .pend_mask        (pend_mask),
    .count            (count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of accepted entries plus the write-port state.
  typedef struct {
    logic        s1v;
    logic [4:0]  s1r;
    logic [31:0] s1d;
    logic        s2v;
    logic [4:0]  s2r;
    logic [31:0] s2d;
  } m_entry_t;

  m_entry_t    mq[$];
  logic        m_f1, m_f2;
  logic [4:0]  m_r1, m_r2;
  logic [31:0] m_d1, m_d2;

  typedef struct {
    logic        v1;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic        v2;
    logic [4:0]  r2;
    logic [31:0] d2;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
    logic        e_f1;
    logic [4:0]  e_r1;
    logic [31:0] e_d1;
    logic        e_f2;
    logic [4:0]  e_r2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t       tbl [8];
  logic [4:0] seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] m = '0;
    foreach (mq[i]) begin
      if (mq[i].s1v) m[mq[i].s1r] = 1'b1;
      if (mq[i].s2v) m[mq[i].s2r] = 1'b1;
    end
    if (!m_f1) m[m_r1] = 1'b1;
    if (!m_f2) m[m_r2] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_f1 = 1'b1; m_f2 = 1'b1;
    m_r1 = 5'd0; m_r2 = 5'd0;
    m_d1 = 32'd0; m_d2 = 32'd0;
  endtask

  task automatic model_edge(input logic fl, input logic v1, input logic [4:0] r1,
                            input logic [31:0] d1, input logic v2, input logic [4:0] r2,
                            input logic [31:0] d2);
    m_entry_t e;
    logic     accept;
    accept = (mq.size() < 4) && !fl;
    if (fl) begin
      mq.delete();
      m_f1 = 1'b1;
      m_f2 = 1'b1;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_f1 = !e.s1v; m_r1 = e.s1r; m_d1 = e.s1d;
        m_f2 = !e.s2v; m_r2 = e.s2r; m_d2 = e.s2d;
      end else begin
        m_f1 = 1'b1;
        m_f2 = 1'b1;
      end
      e.s2v = v2 && (r2 != 5'd0);
      e.s1v = v1 && (r1 != 5'd0) && !(e.s2v && (r1 == r2));
      e.s1r = r1; e.s1d = d1;
      e.s2r = r2; e.s2d = d2;
      if (accept && (e.s1v || e.s2v)) mq.push_back(e);
    end
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".flag1"}, 32'(write_reg_flag_1), 32'(m_f1));
    chk({tag, ".flag2"}, 32'(write_reg_flag_2), 32'(m_f2));
    if (!m_f1) begin
      chk({tag, ".reg1"},  32'(write_reg_1), 32'(m_r1));
      chk({tag, ".data1"}, write_data_1, m_d1);
    end
    if (!m_f2) begin
      chk({tag, ".reg2"},  32'(write_reg_2), 32'(m_r2));
      chk({tag, ".data2"}, write_data_2, m_d2);
    end
    chk({tag, ".pend"},  pend_mask, model_pend());
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic fl, input logic v1, input logic [4:0] r1,
                       input logic [31:0] d1, input logic v2, input logic [4:0] r2,
                       input logic [31:0] d2);
    flush = fl;
    res_valid_1 = v1; res_reg_1 = r1; res_data_1 = d1;
    res_valid_2 = v2; res_reg_2 = r2; res_data_2 = d2;
    #1;
    chk("res_ready", 32'(res_ready), 32'(rst_n && (mq.size() < 4) && !fl));
    @(posedge clk);
    model_edge(fl, v1, r1, d1, v2, r2, d2);
    @(negedge clk);
    model_compare("model");
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".flag1"}, 32'(write_reg_flag_1), 32'd1);
    chk({tag, ".flag2"}, 32'(write_reg_flag_2), 32'd1);
    chk({tag, ".reg1"},  32'(write_reg_1), 32'd0);
    chk({tag, ".reg2"},  32'(write_reg_2), 32'd0);
    chk({tag, ".data1"}, write_data_1, 32'd0);
    chk({tag, ".data2"}, write_data_2, 32'd0);
    chk({tag, ".pend"},  pend_mask, 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".ready"}, 32'(res_ready), 32'd0);
  endtask

  // Called just after a falling edge: pulses rst_n low between clock edges.
  task automatic pulse_reset();
    flush = 1'b0; res_valid_1 = 1'b0; res_valid_2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    model_compare("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            v1  r1     d1             v2  r2     d2             cnt   pend            f1  r1    d1             f2  r2     d2
    tbl[0] = '{1'b1, 5'd8,  32'h0000_1234, 1'b0, 5'd0,  32'h0,         3'd1, 32'h0000_0100, 1'b0, 5'd8, 32'h0000_1234, 1'b1, 5'd0,  32'h0};
    tbl[1] = '{1'b1, 5'd9,  32'h0000_000A, 1'b1, 5'd9,  32'h0000_000B, 3'd1, 32'h0000_0200, 1'b1, 5'd0, 32'h0,         1'b0, 5'd9,  32'h0000_000B};
    tbl[2] = '{1'b1, 5'd0,  32'h0000_0005, 1'b0, 5'd0,  32'h0,         3'd0, 32'h0000_0000, 1'b1, 5'd0, 32'h0,         1'b1, 5'd0,  32'h0};
    tbl[3] = '{1'b1, 5'd3,  32'h0000_0033, 1'b1, 5'd4,  32'h0000_0044, 3'd1, 32'h0000_0018, 1'b0, 5'd3, 32'h0000_0033, 1'b0, 5'd4,  32'h0000_0044};
    tbl[4] = '{1'b0, 5'd7,  32'h0000_0077, 1'b1, 5'd0,  32'h0000_0099, 3'd0, 32'h0000_0000, 1'b1, 5'd0, 32'h0,         1'b1, 5'd0,  32'h0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFF_FFFF, 3'd1, 32'h8000_0000, 1'b1, 5'd0, 32'h0,         1'b0, 5'd31, 32'hFFFF_FFFF};
    tbl[6] = '{1'b1, 5'd5,  32'h0000_0055, 1'b1, 5'd0,  32'h0000_0066, 3'd1, 32'h0000_0020, 1'b0, 5'd5, 32'h0000_0055, 1'b1, 5'd0,  32'h0};
    tbl[7] = '{1'b1, 5'd6,  32'h0000_0066, 1'b1, 5'd7,  32'h0000_0077, 3'd1, 32'h0000_00C0, 1'b0, 5'd6, 32'h0000_0066, 1'b0, 5'd7,  32'h0000_0077};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");

    // Release reset on a falling edge; the very next rising edge must accept.
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("first_enq.count", 32'(count), 32'd1);
    idle();
    chk("single.flag1", 32'(write_reg_flag_1), 32'd0);
    chk("single.reg1",  32'(write_reg_1), 32'd8);
    chk("single.data1", write_data_1, 32'h1234);
    chk("single.flag2", 32'(write_reg_flag_2), 32'd1);
    idle();
    chk("single_done.flag1", 32'(write_reg_flag_1), 32'd1);
    chk("single_done.flag2", 32'(write_reg_flag_2), 32'd1);
    chk("single_done.pend",  pend_mask, 32'd0);
    chk("hold.reg1",  32'(write_reg_1), 32'd8);
    chk("hold.data1", write_data_1, 32'h1234);

    // Directed single-transaction vectors, each starting from an empty buffer.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, tbl[i].v1, tbl[i].r1, tbl[i].d1, tbl[i].v2, tbl[i].r2, tbl[i].d2);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.pend", i),  pend_mask, tbl[i].e_pend);
      idle();
      chk($sformatf("vec%0d.flag1", i), 32'(write_reg_flag_1), 32'(tbl[i].e_f1));
      chk($sformatf("vec%0d.flag2", i), 32'(write_reg_flag_2), 32'(tbl[i].e_f2));
      if (!tbl[i].e_f1) begin
        chk($sformatf("vec%0d.reg1", i),  32'(write_reg_1), 32'(tbl[i].e_r1));
        chk($sformatf("vec%0d.data1", i), write_data_1, tbl[i].e_d1);
      end
      if (!tbl[i].e_f2) begin
        chk($sformatf("vec%0d.reg2", i),  32'(write_reg_2), 32'(tbl[i].e_r2));
        chk($sformatf("vec%0d.data2", i), write_data_2, tbl[i].e_d2);
      end
      idle();
      chk($sformatf("vec%0d.idle_flags", i), 32'({write_reg_flag_1, write_reg_flag_2}), 32'd3);
    end

    // Pending bits follow a result until the edge after its write.
    cycle(1'b0, 1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
    chk("pend24.queued", pend_mask & 32'h3000, 32'h3000);
    idle();
    chk("pend24.writing", pend_mask & 32'h3000, 32'h3000);
    idle();
    chk("pend24.cleared", pend_mask, 32'd0);

    // Back-to-back dual-lane traffic across the pointer wrap.
    seen.delete();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) cycle(1'b0, 1'b1, 5'(2*k+1), 32'((2*k+1) * 32'h111),
                       1'b1, 5'(2*k+2), 32'((2*k+2) * 32'h111));
      else idle();
      chk("stream.count_le4", 32'(count <= 3'd4), 32'd1);
      if (!write_reg_flag_1) seen.push_back(write_reg_1);
      if (!write_reg_flag_2) seen.push_back(write_reg_2);
    end
    chk("stream.num_writes", 32'(seen.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < seen.size()) chk($sformatf("stream.order%0d", k), 32'(seen[k]), 32'(k + 1));
    end

    // Flush with one entry buffered and another on the write port.
    cycle(1'b0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0, 32'd0);
    chk("flush.pend_before", pend_mask, 32'h0000_0C00);
    cycle(1'b1, 1'b1, 5'd14, 32'hE0, 1'b0, 5'd0, 32'd0);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.flags", 32'({write_reg_flag_1, write_reg_flag_2}), 32'd3);
    chk("flush.pend",  pend_mask, 32'd0);
    idle();
    chk("flush.no_write", 32'({write_reg_flag_1, write_reg_flag_2}), 32'd3);

    // Reset mid-operation discards buffered results.
    cycle(1'b0, 1'b1, 5'd20, 32'h200, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b1, 5'd21, 32'h210, 1'b1, 5'd22, 32'h220);
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("reset_mid.no_write", 32'({write_reg_flag_1, write_reg_flag_2}), 32'd3);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic        fl, v1, v2;
      logic [4:0]  r1, r2;
      logic [31:0] d1, d2;
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        fl = ($urandom_range(0, 15) == 0);
        v1 = ($urandom_range(0, 3) != 0);
        v2 = ($urandom_range(0, 3) != 0);
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        d1 = $urandom;
        d2 = $urandom;
        cycle(fl, v1, r1, d1, v2, r2, d2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
